// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 decrypt sequencer: round count, FSM
// states, round-datapath mode encodings and the 128-bit block type.
package aes_pkg;

  localparam int NR = 10;

  typedef logic [127:0] block_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRST,
    ST_MID,
    ST_LAST,
    ST_HOLD
  } state_t;

  typedef enum logic [1:0] {
    MODE_FIRST = 2'd0,
    MODE_MID   = 2'd1,
    MODE_LAST  = 2'd2
  } rnd_mode_t;

endpackage

// File: rtl/aes_decrypt_sequencer.sv
// AES-128 inverse-cipher sequencer: walks one block through an external shared
// round datapath and key expander, one round per clock, with ready/valid I/O.
module aes_decrypt_sequencer #(
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  input  logic         flush,
  output logic [127:0] kx_key,
  output logic [3:0]   rnd_key_idx,
  input  logic [127:0] round_key,
  output logic [1:0]   rnd_mode,
  output logic [127:0] rnd_in,
  input  logic [127:0] rnd_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);

  import aes_pkg::*;

  state_t    state_q, state_d;
  block_t    data_q, data_d;
  block_t    key_q, key_d;
  block_t    pt_q, pt_d;
  logic [3:0] cnt_q, cnt_d;
  logic      ov_q, ov_d;
  logic      accept;
  rnd_mode_t mode;

  // The round key travels expander -> datapath directly; the port only
  // completes the shared-bus interface and is not consumed here.
  logic unused_round_key;
  assign unused_round_key = ^round_key;

  // NOTE: every comb output gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    key_d       = key_q;
    cnt_d       = cnt_q;
    pt_d        = pt_q;
    ov_d        = ov_q;
    mode        = MODE_LAST;
    rnd_key_idx = 4'd0;
    in_ready    = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    accept      = in_valid && in_ready && !flush;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d  = ciphertext;
          key_d   = key;
          state_d = ST_FIRST;
        end
      end
      ST_FIRST: begin
        mode        = MODE_FIRST;
        rnd_key_idx = 4'(NR);
        data_d      = rnd_out;
        cnt_d       = 4'(NR - 1);
        state_d     = ST_MID;
      end
      ST_MID: begin
        mode        = MODE_MID;
        rnd_key_idx = cnt_q;
        data_d      = rnd_out;
        cnt_d       = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_LAST;
      end
      ST_LAST: begin
        pt_d    = rnd_out;
        ov_d    = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          ov_d = 1'b0;
          if (accept) begin
            data_d  = ciphertext;
            key_d   = key;
            state_d = ST_FIRST;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over any accept or consume in the same cycle.
    if (flush) begin
      state_d = ST_IDLE;
      ov_d    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      key_q   <= '0;
      pt_q    <= '0;
      cnt_q   <= 4'd0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
    end
  end

  assign rnd_in    = data_q;
  assign rnd_mode  = mode;
  assign kx_key    = key_q;
  assign plaintext = pt_q;
  assign out_valid = ov_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_decrypt_sequencer.sv
// Bench for aes_decrypt_sequencer: supplies a behavioural key expander and
// inverse round datapath, then checks known-answer vectors and corner sequences.
module tb_aes_decrypt_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] ciphertext = '0;
  logic [127:0] key = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] kx_key, round_key, rnd_in, rnd_out, plaintext;
  logic [3:0]   rnd_key_idx;
  logic [1:0]   rnd_mode;

  int total = 0;
  int bad   = 0;

  aes_decrypt_sequencer #(.NR(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ciphertext(ciphertext), .key(key), .flush(flush), .kx_key(kx_key),
    .rnd_key_idx(rnd_key_idx), .round_key(round_key), .rnd_mode(rnd_mode),
    .rnd_in(rnd_in), .rnd_out(rnd_out), .out_valid(out_valid),
    .out_ready(out_ready), .plaintext(plaintext), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- behavioural AES helpers ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p, r;
    p = x; r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return ginv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] round_key_of(input logic [127:0] k, input logic [3:0] idx);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    int          r;
    w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    r = int'(idx);
    if (r > 10) return '0;
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic [1:0] mode);
    logic [127:0] x, y;
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    x = s ^ rk;
    if (mode != 2'd0 && mode != 2'd1) return x;
    for (int i = 0; i < 16; i++) b[i] = x[127-8*i -: 8];
    if (mode == 2'd1) begin
      for (int c = 0; c < 4; c++) begin
        t[4*c+0] = gmul(b[4*c], 8'h0e) ^ gmul(b[4*c+1], 8'h0b) ^ gmul(b[4*c+2], 8'h0d) ^ gmul(b[4*c+3], 8'h09);
        t[4*c+1] = gmul(b[4*c], 8'h09) ^ gmul(b[4*c+1], 8'h0e) ^ gmul(b[4*c+2], 8'h0b) ^ gmul(b[4*c+3], 8'h0d);
        t[4*c+2] = gmul(b[4*c], 8'h0d) ^ gmul(b[4*c+1], 8'h09) ^ gmul(b[4*c+2], 8'h0e) ^ gmul(b[4*c+3], 8'h0b);
        t[4*c+3] = gmul(b[4*c], 8'h0b) ^ gmul(b[4*c+1], 8'h0d) ^ gmul(b[4*c+2], 8'h09) ^ gmul(b[4*c+3], 8'h0e);
      end
      b = t;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c+r] = b[4*((c - r + 4) % 4) + r];
    for (int i = 0; i < 16; i++) y[127-8*i -: 8] = inv_sbox(t[i]);
    return y;
  endfunction

  always_comb round_key = round_key_of(kx_key, rnd_key_idx);
  always_comb rnd_out   = inv_round(rnd_in, round_key, rnd_mode);

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    ciphertext = {$urandom, $urandom, $urandom, $urandom};
    key        = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic offer(input logic [127:0] c, input logic [127:0] k, input string name);
    in_valid = 1'b1; ciphertext = c; key = k;
    #1;
    check({name, "_in_ready"}, 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
    scramble();
    check({name, "_busy"}, 128'(busy), 128'd1);
  endtask

  task automatic wait_out(input bit do_trace, input string name, output int lat);
    logic [5:0] exp_trace;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (do_trace && lat <= 10) begin
        exp_trace = {4'(10 - lat), (lat == 0) ? 2'd0 : (lat == 10) ? 2'd2 : 2'd1};
        check($sformatf("%s_trace%0d", name, lat), 128'({rnd_key_idx, rnd_mode}), 128'(exp_trace));
      end
      step();
      lat++;
    end
  endtask

  task automatic release_out(input string name);
    out_ready = 1'b1;
    #1;
    check({name, "_ready_in_hold"}, 128'(in_ready), 128'd1);
    step();
    out_ready = 1'b0;
    check({name, "_valid_dropped"}, 128'(out_valid), 128'd0);
    check({name, "_idle"}, 128'(busy), 128'd0);
  endtask

  typedef struct {
    logic [127:0] ct;
    logic [127:0] key;
    logic [127:0] pt;
    int           hold;
  } vec_t;

  vec_t vecs [3];

  initial begin
    int lat, lat2;
    bit seen;
    logic [127:0] held;

    vecs[0] = '{ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, key: 128'h000102030405060708090a0b0c0d0e0f,
                pt: 128'h00112233445566778899aabbccddeeff, hold: 0};
    vecs[1] = '{ct: 128'h3925841d02dc09fbdc118597196a0b32, key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                pt: 128'h3243f6a8885a308d313198a2e0370734, hold: 5};
    vecs[2] = '{ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, key: 128'h0,
                pt: 128'h0, hold: 2};

    // Reset state
    repeat (2) step();
    check("rst_in_ready",  128'(in_ready), 128'd1);
    check("rst_busy",      128'(busy), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_plaintext", plaintext, 128'd0);
    check("rst_kx_key",    kx_key, 128'd0);
    check("rst_idx",       128'(rnd_key_idx), 128'd0);
    check("rst_mode",      128'(rnd_mode), 128'd2);
    check("rst_rnd_in",    rnd_in, 128'd0);
    rst = 1'b1;
    step();

    // Known-answer vectors with index trace and backpressure
    for (int i = 0; i < 3; i++) begin
      offer(vecs[i].ct, vecs[i].key, $sformatf("v%0d", i));
      wait_out(1'b1, $sformatf("v%0d", i), lat);
      check($sformatf("v%0d_latency", i), 128'(lat), 128'd11);
      check($sformatf("v%0d_plaintext", i), plaintext, vecs[i].pt);
      held = plaintext;
      for (int h = 0; h < vecs[i].hold; h++) begin
        step();
        check($sformatf("v%0d_bp%0d_pt", i, h), plaintext, held);
        check($sformatf("v%0d_bp%0d_valid", i, h), 128'(out_valid), 128'd1);
        check($sformatf("v%0d_bp%0d_in_ready", i, h), 128'(in_ready), 128'd0);
      end
      release_out($sformatf("v%0d", i));
    end

    // Back-to-back acceptance in HOLD
    offer(vecs[0].ct, vecs[0].key, "b2b_a");
    wait_out(1'b0, "b2b_a", lat);
    check("b2b_a_latency", 128'(lat), 128'd11);
    out_ready = 1'b1; in_valid = 1'b1;
    ciphertext = vecs[1].ct; key = vecs[1].key;
    #1;
    check("b2b_in_ready", 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    scramble();
    check("b2b_valid_low", 128'(out_valid), 128'd0);
    check("b2b_first_idx", 128'(rnd_key_idx), 128'd10);
    wait_out(1'b0, "b2b_b", lat2);
    check("b2b_gap", 128'(lat2 + 1), 128'd12);
    check("b2b_plaintext", plaintext, vecs[1].pt);
    release_out("b2b_b");

    // Flush during MID with a competing offer
    offer(vecs[0].ct, vecs[0].key, "fl");
    repeat (5) step();
    check("fl_idx_at_flush", 128'(rnd_key_idx), 128'd5);
    check("fl_mode_at_flush", 128'(rnd_mode), 128'd1);
    flush = 1'b1; in_valid = 1'b1;
    ciphertext = vecs[2].ct; key = vecs[2].key;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_idle", 128'(busy), 128'd0);
    check("fl_valid", 128'(out_valid), 128'd0);
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (out_valid || busy) seen = 1'b1;
    end
    check("fl_quiet", 128'(seen), 128'd0);

    // Asynchronous reset mid-block, then a clean decrypt
    offer(vecs[0].ct, vecs[0].key, "ar");
    repeat (4) step();
    #2 rst = 1'b0;
    #1;
    check("ar_in_ready",  128'(in_ready), 128'd1);
    check("ar_busy",      128'(busy), 128'd0);
    check("ar_out_valid", 128'(out_valid), 128'd0);
    check("ar_plaintext", plaintext, 128'd0);
    check("ar_kx_key",    kx_key, 128'd0);
    check("ar_idx",       128'(rnd_key_idx), 128'd0);
    check("ar_mode",      128'(rnd_mode), 128'd2);
    check("ar_rnd_in",    rnd_in, 128'd0);
    step();
    rst = 1'b1;
    step();
    offer(vecs[0].ct, vecs[0].key, "ar2");
    wait_out(1'b1, "ar2", lat);
    check("ar2_latency", 128'(lat), 128'd11);
    check("ar2_plaintext", plaintext, vecs[0].pt);
    release_out("ar2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_decrypt_sequencer.md
AES_DECRYPT_SEQUENCER -- requirements
Module: aes_decrypt_sequencer

Interface
REQ-001 Parameter NR, default 10: number of AES rounds; only 10 (AES-128) is supported.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  ciphertext/key offered.
REQ-005 in_ready  out  1  sequencer can accept a block.
REQ-006 ciphertext  in  128  block to decrypt.
REQ-007 key  in  128  cipher key, round-0 key.
REQ-008 flush  in  1  synchronous abort of the current block.
REQ-009 kx_key  out  128  latched cipher key driven to the shared key_expand instance.
REQ-010 rnd_key_idx  out  4  round-key index requested from the key expander (0..10).
REQ-011 round_key  in  128  combinational round key for rnd_key_idx.
REQ-012 rnd_mode  out  2  shared round-datapath mode: 0 FIRST (AddRoundKey, InvShiftRows, InvSubBytes), 1 MID (AddRoundKey, InvMixColumns, InvShiftRows, InvSubBytes), 2 LAST (AddRoundKey only), 3 unused.
REQ-013 rnd_in  out  128  state word presented to the shared combinational round datapath.
REQ-014 rnd_out  in  128  round datapath result.
REQ-015 out_valid  out  1  plaintext is valid.
REQ-016 out_ready  in  1  consumer accepts plaintext.
REQ-017 plaintext  out  128  decrypted block.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, FIRST, MID, LAST, HOLD.
REQ-020 in_ready SHALL be 1 in IDLE, and in HOLD when out_ready=1; otherwise 0.
REQ-021 Accept (in_valid & in_ready & !flush): latch ciphertext into state_q and key into kx_key, then go to FIRST.
REQ-022 FIRST: rnd_key_idx=10, rnd_mode=0; on the next edge state_q<=rnd_out, round counter<=9, go to MID.
REQ-023 MID: rnd_key_idx=counter, rnd_mode=1; each edge state_q<=rnd_out and the counter decrements; the edge leaving counter=1 goes to LAST.
REQ-024 LAST: rnd_key_idx=0, rnd_mode=2; next edge plaintext<=rnd_out, out_valid<=1, go to HOLD.
REQ-025 Latency: out_valid SHALL rise exactly 11 clock edges after the accepting edge (1 FIRST + 9 MID + 1 LAST).
REQ-026 HOLD: plaintext and out_valid stable until out_ready=1. On that edge, go to FIRST if a new block is accepted the same cycle (back-to-back), else go to IDLE with out_valid<=0.
REQ-027 rnd_in SHALL equal state_q in all states; in IDLE/HOLD rnd_mode=2 and rnd_key_idx=0.
REQ-028 ciphertext/key changes after acceptance SHALL NOT affect the block in flight.
REQ-029 flush=1 SHALL force IDLE on the next edge from any state, with out_valid<=0 and no acceptance that cycle; flush overrides simultaneous in_valid and out_ready.
REQ-030 in_valid while busy (outside REQ-026) SHALL be ignored; the offer is held by the producer.
REQ-031 Counter range 0..10, 4 bits; no wrap SHALL occur (the MID exit is at 1).

Reset
REQ-032 rst=0 SHALL immediately force IDLE, with in_ready=1, busy=0, out_valid=0, plaintext=0, state_q=0, kx_key=0, counter=0, rnd_key_idx=0, rnd_mode=2.
REQ-033 Reset mid-operation SHALL discard the block; the first acceptance after rst deasserts SHALL behave as from power-up.

Structure
REQ-034 Shared package aes_pkg SHALL hold NR, the FSM state enum, rnd_mode encodings, and the 128-bit block typedef.
REQ-035 Single module, with no sub-module; the round datapath and key_expand remain external and shared, and are driven via the rnd_* and kx_* ports.

Verification
REQ-036 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff, out_valid 11 edges after acceptance.
REQ-037 Index trace: rnd_key_idx SHALL be 10,9,8,...,1,0 and rnd_mode SHALL be 0, then nine 1s, then 2, over the consecutive cycles after acceptance.
REQ-038 Back-to-back: second block offered in HOLD with out_ready=1 -> accepted that edge; second out_valid exactly 12 edges after the first rose.
REQ-039 Backpressure: out_ready=0 for 5 cycles -> plaintext stable, in_ready=0 throughout; release -> IDLE.
REQ-040 flush during MID (counter=5) together with in_valid=1 -> IDLE next edge, no acceptance, out_valid never rises.
REQ-041 rst pulse low during MID -> all outputs at reset values asynchronously; the subsequent C.1 vector decrypts correctly.
